vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 timing for the on-screen clock display.
- Sits directly upstream of the digit-rendering stage. Drives its h_sinc/v_sinc inputs, and also supplies pixel coordinates and blanking so that stage no longer has to run its own counters.
- Pixel rate is derived from clk by a programmable clock-enable divider.
- All outputs are registered and mutually aligned.

Parameters:
- CLK_DIV, 2: clk cycles per pixel (1 = clk is the pixel clock; 2 = 50 MHz clk to 25 MHz pixel rate). Must be >= 1.
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VIS, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_ACT, 0: active level of h_sinc/v_sinc (0 = active-low).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_ce  out  1  one-clk pulse marking each pixel advance.
- h_sinc  out  1  horizontal sync, level set by SYNC_ACT.
- v_sinc  out  1  vertical sync, level set by SYNC_ACT.
- video_on  out  1  high while (h_cnt, v_cnt) is inside the visible area.
- h_cnt  out  11  horizontal position, 0..H_TOT-1.
- v_cnt  out  11  vertical position, 0..V_TOT-1.
- line_start  out  1  one-clk pulse when h_cnt wraps to 0.
- frame_start  out  1  one-clk pulse when (h_cnt, v_cnt) becomes (0,0).

Behaviour:
- Derived totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525). Counters are 11 bits and must hold H_TOT-1 and V_TOT-1; width mismatch is an elaboration error.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 on every clk.
  - pix_ce is registered and high on the clk where div_cnt == CLK_DIV-1.
  - CLK_DIV = 1 gives pix_ce high continuously after reset.
- Reset values (asynchronous, while rst_n = 0):
  - div_cnt = 0, pix_ce = 0.
  - h_cnt = H_TOT-1, v_cnt = V_TOT-1.
  - h_sinc = v_sinc = !SYNC_ACT; video_on = 0.
  - line_start = 0, frame_start = 0.
- First pixel: the first pix_ce tick after reset release wraps both counters to (0,0) and asserts line_start and frame_start.
  - That tick occurs on the CLK_DIV-th rising clk edge after rst_n deasserts.
- Counter update (on each pix_ce tick only; all outputs hold between ticks):
  - If h_cnt == H_TOT-1: h_cnt <= 0.
    - If also v_cnt == V_TOT-1: v_cnt <= 0.
    - Otherwise v_cnt <= v_cnt+1.
  - Otherwise h_cnt <= h_cnt+1 and v_cnt holds.
- Decodes are computed from the next counter values and registered with them, so every output describes the same (h_cnt, v_cnt) pair in the same cycle (zero relative skew):
  - video_on = (h < H_VIS) && (v < V_VIS).
  - h_sinc = SYNC_ACT when H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751), else !SYNC_ACT.
  - v_sinc = SYNC_ACT when V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (490..491), else !SYNC_ACT.
    - v_sinc depends on v only, so it spans whole lines, edge-aligned to h_cnt = 0.
- Pulses:
  - line_start and frame_start are registered in the same edge as the wrap and are high for exactly one clk, not one pixel.
  - frame_start implies line_start.
- Reset mid-frame: all state returns immediately to reset values. No partial sync pulse may be extended past rst_n assertion.
- No inputs other than clk/rst_n; free-running; no stall.

Test Plan:
- Reset with CLK_DIV=2: hold rst_n=0 for 5 clk -> h_cnt=799, v_cnt=524, h_sinc=v_sinc=1, video_on=0, pix_ce=0. Release -> second rising edge gives pix_ce=1, h_cnt=0, v_cnt=0, video_on=1, line_start=frame_start=1. Both pulses drop the next clk.
- Horizontal timing over one line: h_sinc=0 for exactly 96 pix_ce ticks, starting at h_cnt=656 and ending after h_cnt=751. video_on high for h_cnt 0..639 only. line_start once per 800 ticks.
- Vertical timing over a full frame: v_sinc=0 exactly while v_cnt is 490..491 (1600 ticks). frame_start once per 420000 ticks (840000 clk at CLK_DIV=2).
- Visible pixel count: video_on high on exactly 307200 pix_ce ticks per frame. Last visible pixel is (639,479); the next tick has video_on=0.
- Reset mid-operation: assert rst_n=0 at (700,491), while both syncs are active -> same clk edge returns h_sinc=v_sinc=1 and reset counters. After release, timing restarts per scenario 1.
- CLK_DIV=1 build: pix_ce constantly 1 after reset. Frame period is 420000 clk; all sync widths as above.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator: clock-enable divider, h/v position counters and
// registered decodes (sync, blanking, line/frame pulses) that all describe the same pixel.
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_ACT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_ce,
    output logic        h_sinc,
    output logic        v_sinc,
    output logic        video_on,
    output logic [10:0] h_cnt,
    output logic [10:0] v_cnt,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] H_VIS_L  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_L  = 11'(V_VIS);
    localparam logic [10:0] H_SS     = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SE     = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_SS     = 11'(V_VIS + V_FP);
    localparam logic [10:0] V_SE     = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic SYNC_ON  = (SYNC_ACT != 0);
    localparam logic SYNC_OFF = (SYNC_ACT == 0);

    generate
        if (H_TOT > 2048 || V_TOT > 2048 || CLK_DIV < 1) begin : g_bad_params
            $error("vga_sync_gen: totals exceed 11-bit counters or CLK_DIV < 1");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;
    logic             r_pix_ce;
    logic             r_h_sinc;
    logic             r_v_sinc;
    logic             r_video_on;
    logic [10:0]      r_h_cnt;
    logic [10:0]      r_v_cnt;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_tick;
    logic [10:0]      w_h_next;
    logic [10:0]      w_v_next;

    always_comb begin
        w_tick   = (r_div == DIV_LAST);
        w_h_next = r_h_cnt + 11'd1;
        w_v_next = r_v_cnt;
        if (r_h_cnt == H_LAST) begin
            w_h_next = 11'd0;
            w_v_next = (r_v_cnt == V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Decodes use the next counter values so every output lands with its pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_ce      <= 1'b0;
            r_h_cnt       <= H_LAST;
            r_v_cnt       <= V_LAST;
            r_h_sinc      <= SYNC_OFF;
            r_v_sinc      <= SYNC_OFF;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_ce      <= w_tick;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_h_cnt       <= w_h_next;
                r_v_cnt       <= w_v_next;
                r_video_on    <= (w_h_next < H_VIS_L) && (w_v_next < V_VIS_L);
                r_h_sinc      <= (w_h_next >= H_SS && w_h_next < H_SE) ? SYNC_ON : SYNC_OFF;
                r_v_sinc      <= (w_v_next >= V_SS && w_v_next < V_SE) ? SYNC_ON : SYNC_OFF;
                r_line_start  <= (w_h_next == 11'd0);
                r_frame_start <= (w_h_next == 11'd0) && (w_v_next == 11'd0);
            end
        end
    end

    assign pix_ce      = r_pix_ce;
    assign h_sinc      = r_h_sinc;
    assign v_sinc      = r_v_sinc;
    assign video_on    = r_video_on;
    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full VGA instance (CLK_DIV=2) plus two shrunken-timing
// instances (CLK_DIV=1 active-low sync, CLK_DIV=3 active-high sync) against a pixel-index model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic        pce;
        logic        hs;
        logic        vs;
        logic        von;
        logic        ls;
        logic        fs;
        logic [10:0] h;
        logic [10:0] v;
    } vga_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n_v;
    logic [2:0]  pce_v, hs_v, vs_v, von_v, ls_v, fs_v;
    logic [10:0] h_cnt_v [3];
    logic [10:0] v_cnt_v [3];

    int k [3];
    int checks;
    int errors;

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .clk(clk), .rst_n(rst_n_v[0]), .pix_ce(pce_v[0]), .h_sinc(hs_v[0]), .v_sinc(vs_v[0]),
        .video_on(von_v[0]), .h_cnt(h_cnt_v[0]), .v_cnt(v_cnt_v[0]),
        .line_start(ls_v[0]), .frame_start(fs_v[0])
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACT(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_v[1]), .pix_ce(pce_v[1]), .h_sinc(hs_v[1]), .v_sinc(vs_v[1]),
        .video_on(von_v[1]), .h_cnt(h_cnt_v[1]), .v_cnt(v_cnt_v[1]),
        .line_start(ls_v[1]), .frame_start(fs_v[1])
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACT(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n_v[2]), .pix_ce(pce_v[2]), .h_sinc(hs_v[2]), .v_sinc(vs_v[2]),
        .video_on(von_v[2]), .h_cnt(h_cnt_v[2]), .v_cnt(v_cnt_v[2]),
        .line_start(ls_v[2]), .frame_start(fs_v[2])
    );

    // Expected outputs after k rising edges since reset release: n = k/div pixel
    // ticks have happened, the n-th tick shows pixel index (n-1) mod frame size.
    function automatic vga_t model(input int i);
        int div, hv, hfp, hsw, htot, vv, vfp, vsw, vtot, sa, n, p, h, v;
        vga_t r;
        if (i == 0) begin
            div = 2; hv = 640; hfp = 16; hsw = 96; htot = 800;
            vv = 480; vfp = 10; vsw = 2; vtot = 525; sa = 0;
        end else begin
            div = (i == 1) ? 1 : 3; hv = 16; hfp = 2; hsw = 4; htot = 25;
            vv = 8; vfp = 2; vsw = 2; vtot = 15; sa = (i == 1) ? 0 : 1;
        end
        n = k[i] / div;
        if (n == 0) begin
            r.pce = 1'b0; r.hs = (sa == 0); r.vs = (sa == 0); r.von = 1'b0;
            r.ls = 1'b0; r.fs = 1'b0; r.h = 11'(htot - 1); r.v = 11'(vtot - 1);
        end else begin
            p = (n - 1) % (htot * vtot);
            h = p % htot;
            v = p / htot;
            r.pce = (k[i] % div == 0);
            r.h   = 11'(h);
            r.v   = 11'(v);
            r.von = (h < hv) && (v < vv);
            r.hs  = (h >= hv + hfp && h < hv + hfp + hsw) ? (sa != 0) : (sa == 0);
            r.vs  = (v >= vv + vfp && v < vv + vfp + vsw) ? (sa != 0) : (sa == 0);
            r.ls  = r.pce && (h == 0);
            r.fs  = r.pce && (p == 0);
        end
        return r;
    endfunction

    function automatic vga_t get(input int i);
        vga_t r;
        r.pce = pce_v[i]; r.hs = hs_v[i]; r.vs = vs_v[i]; r.von = von_v[i];
        r.ls = ls_v[i]; r.fs = fs_v[i]; r.h = h_cnt_v[i]; r.v = v_cnt_v[i];
        return r;
    endfunction

    function automatic string fmt(input vga_t r);
        return $sformatf("pce=%b hs=%b vs=%b von=%b ls=%b fs=%b h=%0d v=%0d",
                         r.pce, r.hs, r.vs, r.von, r.ls, r.fs, r.h, r.v);
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) if (rst_n_v[i]) k[i]++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        vga_t exp_r;
        rst_n_v = 3'b000;
        repeat (5) tick();
        exp_r = '{pce: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0, h: 11'd799, v: 11'd524};
        checks++;
        if (get(0) !== exp_r) begin
            errors++; $display("FAIL reset_a: got %s, want %s", fmt(get(0)), fmt(exp_r));
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (get(i) !== model(i)) begin
                errors++; $display("FAIL reset_model[%0d]: got %s, want %s", i, fmt(get(i)), fmt(model(i)));
            end
        end
        rst_n_v = 3'b111;
        tick();
        checks++;
        if (pce_v[0] !== 1'b0 || h_cnt_v[0] !== 11'd799) begin
            errors++; $display("FAIL first_edge_a: got %s, want pce=0 h=799", fmt(get(0)));
        end
        tick();
        exp_r = '{pce: 1'b1, hs: 1'b1, vs: 1'b1, von: 1'b1, ls: 1'b1, fs: 1'b1, h: 11'd0, v: 11'd0};
        checks++;
        if (get(0) !== exp_r) begin
            errors++; $display("FAIL first_pixel_a: got %s, want %s", fmt(get(0)), fmt(exp_r));
        end
        tick();
        checks++;
        if ({pce_v[0], ls_v[0], fs_v[0]} !== 3'b000) begin
            errors++; $display("FAIL pulse_drop_a: got %s, want pce=0 ls=0 fs=0", fmt(get(0)));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (get(i) !== model(i)) begin
                errors++; $display("FAIL release_model[%0d]: got %s, want %s", i, fmt(get(i)), fmt(model(i)));
            end
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_horizontal();
        int started = 0, lines = 0, pix = 0, hs_cnt = 0, von_cnt = 0, hs_first = -1, hs_last = -1;
        for (int c = 0; c < 5000; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (get(i) !== model(i)) begin
                    errors++; $display("FAIL horiz_model[%0d] k=%0d: got %s, want %s", i, k[i], fmt(get(i)), fmt(model(i)));
                end
            end
            if (pce_v[0]) begin
                if (ls_v[0]) begin
                    if (started != 0) begin
                        checks++;
                        if (pix != 800 || hs_cnt != 96 || von_cnt != 640 || hs_first != 656 || hs_last != 751) begin
                            errors++;
                            $display("FAIL line_timing: got ticks=%0d hsync=%0d visible=%0d hs=%0d..%0d, want 800/96/640 656..751",
                                     pix, hs_cnt, von_cnt, hs_first, hs_last);
                        end
                        lines++;
                    end
                    started = 1; pix = 0; hs_cnt = 0; von_cnt = 0; hs_first = -1; hs_last = -1;
                end
                pix++;
                if (hs_v[0] == 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = h_cnt_v[0];
                    hs_last = h_cnt_v[0];
                end
                if (von_v[0]) von_cnt++;
            end
        end
        checks++;
        if (lines < 2) begin
            errors++; $display("FAIL lines_seen: got %0d, want >= 2", lines);
        end
        $display("test_horizontal done: lines=%0d checks=%0d errors=%0d", lines, checks, errors);
    endtask

    task automatic test_frame();
        int started = 0, frames = 0, pix = 0, vs_cnt = 0, von_cnt = 0, ls_cnt = 0, last_vis = 0;
        for (int c = 0; c < 1200; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (get(i) !== model(i)) begin
                    errors++; $display("FAIL frame_model[%0d] k=%0d: got %s, want %s", i, k[i], fmt(get(i)), fmt(model(i)));
                end
            end
            checks++;
            if (pce_v[1] !== 1'b1) begin
                errors++; $display("FAIL pce_div1: got %b, want 1", pce_v[1]);
            end
            if (pce_v[1]) begin
                if (last_vis != 0) begin
                    checks++;
                    if (von_v[1] !== 1'b0 || h_cnt_v[1] !== 11'd16) begin
                        errors++; $display("FAIL after_last_visible: got %s, want von=0 h=16 v=7", fmt(get(1)));
                    end
                    last_vis = 0;
                end
                if (h_cnt_v[1] == 11'd15 && v_cnt_v[1] == 11'd7) begin
                    checks++;
                    if (von_v[1] !== 1'b1) begin
                        errors++; $display("FAIL last_visible: got von=%b, want 1", von_v[1]);
                    end
                    last_vis = 1;
                end
                if (fs_v[1]) begin
                    if (started != 0) begin
                        checks++;
                        if (pix != 375 || vs_cnt != 50 || von_cnt != 128 || ls_cnt != 15) begin
                            errors++;
                            $display("FAIL frame_timing: got ticks=%0d vsync=%0d visible=%0d lines=%0d, want 375/50/128/15",
                                     pix, vs_cnt, von_cnt, ls_cnt);
                        end
                        frames++;
                    end
                    started = 1; pix = 0; vs_cnt = 0; von_cnt = 0; ls_cnt = 0;
                end
                pix++;
                if (vs_v[1] == 1'b0) vs_cnt++;
                if (von_v[1]) von_cnt++;
                if (ls_v[1]) ls_cnt++;
            end
        end
        checks++;
        if (frames < 2) begin
            errors++; $display("FAIL frames_seen: got %0d, want >= 2", frames);
        end
        $display("test_frame done: frames=%0d checks=%0d errors=%0d", frames, checks, errors);
    endtask

    task automatic test_mid_reset();
        int found = 0;
        vga_t exp_r;
        for (int c = 0; c < 800 && found == 0; c++) begin
            tick();
            checks++;
            if (get(1) !== model(1)) begin
                errors++; $display("FAIL seek_b: got %s, want %s", fmt(get(1)), fmt(model(1)));
            end
            if (h_cnt_v[1] == 11'd20 && v_cnt_v[1] == 11'd11) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++; $display("FAIL seek_b_timeout: got no (20,11), want it within 800 clk");
        end else begin
            checks++;
            if (hs_v[1] !== 1'b0 || vs_v[1] !== 1'b0) begin
                errors++; $display("FAIL both_sync_active: got hs=%b vs=%b, want 0 0", hs_v[1], vs_v[1]);
            end
            rst_n_v[1] = 1'b0; k[1] = 0;
            #1;
            exp_r = '{pce: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0, h: 11'd24, v: 11'd14};
            checks++;
            if (get(1) !== exp_r) begin
                errors++; $display("FAIL async_reset_b: got %s, want %s", fmt(get(1)), fmt(exp_r));
            end
        end
        found = 0;
        for (int c = 0; c < 3400 && found == 0; c++) begin
            tick();
            if (pce_v[0] && h_cnt_v[0] == 11'd700) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++; $display("FAIL seek_a_timeout: got no h=700, want it within 3400 clk");
        end else begin
            rst_n_v[0] = 1'b0; k[0] = 0;
            #1;
            checks++;
            if (hs_v[0] !== 1'b1 || h_cnt_v[0] !== 11'd799 || v_cnt_v[0] !== 11'd524 || pce_v[0] !== 1'b0) begin
                errors++; $display("FAIL async_reset_a: got %s, want hs=1 h=799 v=524 pce=0", fmt(get(0)));
            end
        end
        repeat ($urandom_range(1, 4)) tick();
        rst_n_v = 3'b111;
        repeat (20) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (get(i) !== model(i)) begin
                    errors++; $display("FAIL restart_model[%0d] k=%0d: got %s, want %s", i, k[i], fmt(get(i)), fmt(model(i)));
                end
            end
        end
        $display("test_mid_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random_resets();
        int inst;
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(1, 600)) begin
                tick();
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (get(i) !== model(i)) begin
                        errors++; $display("FAIL rand_model[%0d] k=%0d: got %s, want %s", i, k[i], fmt(get(i)), fmt(model(i)));
                    end
                end
            end
            inst = $urandom_range(0, 2);
            rst_n_v[inst] = 1'b0; k[inst] = 0;
            #1;
            checks++;
            if (get(inst) !== model(inst)) begin
                errors++; $display("FAIL rand_reset[%0d]: got %s, want %s", inst, fmt(get(inst)), fmt(model(inst)));
            end
            repeat ($urandom_range(1, 4)) begin
                tick();
                checks++;
                if (get(inst) !== model(inst)) begin
                    errors++; $display("FAIL rand_hold[%0d]: got %s, want %s", inst, fmt(get(inst)), fmt(model(inst)));
                end
            end
            rst_n_v[inst] = 1'b1;
            $display("test_random_resets iter %0d: reset inst %0d, checks=%0d errors=%0d", it, inst, checks, errors);
        end
        repeat (50) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (get(i) !== model(i)) begin
                    errors++; $display("FAIL rand_tail[%0d] k=%0d: got %s, want %s", i, k[i], fmt(get(i)), fmt(model(i)));
                end
            end
        end
    endtask

    initial begin
        rst_n_v = 3'b000;
        k = '{0, 0, 0};
        checks = 0;
        errors = 0;
        test_reset();
        test_horizontal();
        test_frame();
        test_mid_reset();
        test_random_resets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
